// File: rtl/digit_serial_addsub_if.sv
// Handshake and data bundle for digit_serial_addsub.
//   in_valid/in_ready   : operand handshake (a, b, cin, sub travel with it)
//   out_valid/out_ready : result handshake (s, cout, ovf travel with it)
// master = operand producer / result consumer, slave = the adder.
interface digit_serial_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf
    );
endinterface

// File: rtl/digit_serial_addsub.sv
// Digit-serial adder/subtractor: processes DIGIT bits per cycle, LSB digit
// first, so a WIDTH-bit result takes NDIG = WIDTH/DIGIT cycles.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : digit_serial_addsub_if.slave
//          in_valid/in_ready, a, b, cin, sub    - operand side
//          out_valid/out_ready, s, cout, ovf    - result side
// Subtract is a + ~b + ~cin, so cout=1 means "no borrow".
//
// state | meaning
// ------+---------------------------------------------------
// IDLE  | waiting for operands, in_ready=1
// CALC  | one digit per cycle, counter k = 0 .. NDIG-1
// DONE  | result held on s/cout/ovf, out_valid=1 until out_ready
module digit_serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input logic            clk,
    input logic            rst,
    digit_serial_addsub_if.slave bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] s_r;
    logic             carry_r;
    logic             cout_r;
    logic             ovf_r;
    logic [CW-1:0]    dig_cnt;

    logic [DIGIT:0]       dig_sum;
    logic [WIDTH+DIGIT-1:0] s_cat;
    logic                 last_dig;
    logic                 msb_ovf;

    // Operands are shifted right each cycle so the active digit is always
    // in the low DIGIT bits; result digits enter s from the top.
    always_comb begin
        dig_sum  = {1'b0, a_r[DIGIT-1:0]} + {1'b0, b_r[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, carry_r};
        s_cat    = {dig_sum[DIGIT-1:0], s_r};
        last_dig = (dig_cnt == LAST_DIG);
        // Carry into the top bit equals a^b^sum at that bit.
        msb_ovf  = a_r[DIGIT-1] ^ b_r[DIGIT-1] ^ dig_sum[DIGIT-1] ^ dig_sum[DIGIT];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (last_dig) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            s_r     <= '0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            dig_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r     <= bus.a;
                        b_r     <= bus.sub ? ~bus.b : bus.b;
                        carry_r <= bus.sub ? ~bus.cin : bus.cin;
                        dig_cnt <= '0;
                    end
                end
                CALC: begin
                    a_r     <= a_r >> DIGIT;
                    b_r     <= b_r >> DIGIT;
                    s_r     <= WIDTH'(s_cat >> DIGIT);
                    carry_r <= dig_sum[DIGIT];
                    dig_cnt <= dig_cnt + 1'b1;
                    if (last_dig) begin
                        cout_r <= dig_sum[DIGIT];
                        ovf_r  <= msb_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.s    = s_r;
    assign bus.cout = cout_r;
    assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_digit_serial_addsub.sv
module tb_digit_serial_addsub;
    localparam int W    = 16;
    localparam int NDUT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          tb_in_valid;
    logic          tb_cin;
    logic          tb_sub;
    logic          tb_out_ready;
    logic [W-1:0]  tb_a;
    logic [W-1:0]  tb_b;

    logic [NDUT-1:0] ov;
    logic [NDUT-1:0] ir;
    logic [NDUT-1:0] co;
    logic [NDUT-1:0] of;
    logic [W-1:0]    so [NDUT];

    int n_cmp = 0;
    int n_err = 0;
    string cur_tag = "";

    function automatic int dig_of(input int g);
        case (g)
            0:       return 4;
            1:       return 16;
            2:       return 8;
            default: return 1;
        endcase
    endfunction

    digit_serial_addsub_if #(.WIDTH(W)) bus [NDUT] ();

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int D = (g == 0) ? 4 : (g == 1) ? 16 : (g == 2) ? 8 : 1;
        digit_serial_addsub #(.WIDTH(W), .DIGIT(D)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus[g])
        );
        assign bus[g].in_valid  = tb_in_valid;
        assign bus[g].a         = tb_a;
        assign bus[g].b         = tb_b;
        assign bus[g].cin       = tb_cin;
        assign bus[g].sub       = tb_sub;
        assign bus[g].out_ready = tb_out_ready;
        assign ov[g] = bus[g].out_valid;
        assign ir[g] = bus[g].in_ready;
        assign co[g] = bus[g].cout;
        assign of[g] = bus[g].ovf;
        assign so[g] = bus[g].s;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s %s dut%0d(DIGIT=%0d): got %0h expected %0h",
                     cur_tag, name, g, dig_of(g), act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic sb,
                         output logic [W-1:0] s, output logic c, output logic o);
        int ua, ub, sa, sbv, cc, u, r;
        ua  = int'(a);
        ub  = int'(b);
        sa  = int'($signed(a));
        sbv = int'($signed(b));
        cc  = ci ? 1 : 0;
        if (sb) begin
            u = ua - ub - cc;
            r = sa - sbv - cc;
            c = (u >= 0);
        end else begin
            u = ua + ub + cc;
            r = sa + sbv + cc;
            c = (u > 65535);
        end
        s = u[W-1:0];
        o = (r > 32767) || (r < -32768);
    endtask

    // One full transaction on all four DUTs in parallel.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic sb,
                         input logic [W-1:0] es, input logic ec, input logic eo);
        logic [NDUT-1:0] seen;
        for (int g = 0; g < NDUT; g++) chk("in_ready_idle", g, ir[g], 1);
        tb_a = a; tb_b = b; tb_cin = ci; tb_sub = sb; tb_in_valid = 1'b1;
        tick();
        // Scramble the inputs and keep in_valid high: must be ignored.
        tb_a = W'($urandom); tb_b = W'($urandom);
        tb_cin = 1'($urandom); tb_sub = 1'($urandom);
        seen = '0;
        for (int cyc = 1; cyc <= 24 && seen != '1; cyc++) begin
            tick();
            for (int g = 0; g < NDUT; g++) begin
                if (seen[g]) begin
                    chk("hold_s", g, so[g], es);
                    chk("hold_valid", g, ov[g], 1);
                    chk("hold_in_ready", g, ir[g], 0);
                end else if (ov[g]) begin
                    seen[g] = 1'b1;
                    chk("latency", g, cyc, W / dig_of(g));
                    chk("s", g, so[g], es);
                    chk("cout", g, co[g], ec);
                    chk("ovf", g, of[g], eo);
                end else begin
                    chk("calc_in_ready", g, ir[g], 0);
                end
            end
        end
        for (int g = 0; g < NDUT; g++) if (!seen[g]) chk("out_valid_timeout", g, ov[g], 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            for (int g = 0; g < NDUT; g++) begin
                chk("stall_s", g, so[g], es);
                chk("stall_cout", g, co[g], ec);
                chk("stall_ovf", g, of[g], eo);
                chk("stall_in_ready", g, ir[g], 0);
            end
        end
        tb_in_valid = 1'b0;
        tb_out_ready = 1'b1;
        tick();
        tb_out_ready = 1'b0;
        for (int g = 0; g < NDUT; g++) begin
            chk("post_in_ready", g, ir[g], 1);
            chk("post_out_valid", g, ov[g], 0);
            chk("retain_s", g, so[g], es);
        end
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] ra, rb, es;
        logic rc, rs, ec, eo;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[4] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[7] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};

        rst = 1'b1;
        tb_in_valid = 1'b0; tb_out_ready = 1'b0;
        tb_a = '0; tb_b = '0; tb_cin = 1'b0; tb_sub = 1'b0;
        tick(); tick();
        rst = 1'b0;
        cur_tag = "reset";
        for (int g = 0; g < NDUT; g++) begin
            chk("in_ready", g, ir[g], 1);
            chk("out_valid", g, ov[g], 0);
            chk("s", g, so[g], 0);
            chk("cout", g, co[g], 0);
            chk("ovf", g, of[g], 0);
        end

        for (int i = 0; i < 8; i++) begin
            cur_tag = $sformatf("vec%0d", i);
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                  vecs[i].s, vecs[i].cout, vecs[i].ovf);
        end

        // Reset in the 2nd CALC cycle abandons the operation.
        cur_tag = "rst_calc";
        tb_a = 16'hFFFF; tb_b = 16'h0001; tb_cin = 1'b0; tb_sub = 1'b0; tb_in_valid = 1'b1;
        tick();
        tb_in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int g = 0; g < NDUT; g++) begin
            chk("in_ready", g, ir[g], 1);
            chk("out_valid", g, ov[g], 0);
            chk("s", g, so[g], 0);
            chk("cout", g, co[g], 0);
            chk("ovf", g, of[g], 0);
        end
        tick();
        for (int g = 0; g < NDUT; g++) chk("no_result", g, ov[g], 0);
        cur_tag = "after_rst";
        do_op(vecs[1].a, vecs[1].b, vecs[1].cin, vecs[1].sub,
              vecs[1].s, vecs[1].cout, vecs[1].ovf);

        // in_valid together with rst must not be accepted.
        cur_tag = "rst_in_valid";
        rst = 1'b1; tb_in_valid = 1'b1; tb_a = 16'h0101; tb_b = 16'h0202;
        tick();
        rst = 1'b0; tb_in_valid = 1'b0;
        tick();
        for (int g = 0; g < NDUT; g++) begin
            chk("in_ready", g, ir[g], 1);
            chk("out_valid", g, ov[g], 0);
        end

        for (int i = 0; i < 1000; i++) begin
            cur_tag = $sformatf("rnd%0d", i);
            case ($urandom_range(0, 7))
                0:       ra = 16'hFFFF;
                1:       ra = 16'h8000;
                2:       ra = 16'h7FFF;
                default: ra = W'($urandom);
            endcase
            rb = ($urandom_range(0, 7) == 0) ? 16'h0000 : W'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            model(ra, rb, rc, rs, es, ec, eo);
            do_op(ra, rb, rc, rs, es, ec, eo);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
